// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   state_e         : responder FSM states (idle / latency wait / response hold)
//   DefaultBaseAddr : default byte address of array word 0
//   Strb*           : byte-strobe patterns accepted when strobe checking is enabled
//   strb_legal()    : 1 when a 4-lane strobe is an aligned byte, half-word or word
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    localparam logic [31:0] DefaultBaseAddr = 32'h0100_0000;

    localparam logic [3:0] StrbNone   = 4'b0000;
    localparam logic [3:0] StrbByte0  = 4'b0001;
    localparam logic [3:0] StrbByte1  = 4'b0010;
    localparam logic [3:0] StrbByte2  = 4'b0100;
    localparam logic [3:0] StrbByte3  = 4'b1000;
    localparam logic [3:0] StrbHalfLo = 4'b0011;
    localparam logic [3:0] StrbHalfHi = 4'b1100;
    localparam logic [3:0] StrbWord   = 4'b1111;

    function automatic logic strb_legal(input logic [3:0] strb);
        logic legal;
        case (strb)
            StrbNone, StrbByte0, StrbByte1, StrbByte2, StrbByte3,
            StrbHalfLo, StrbHalfHi, StrbWord: legal = 1'b1;
            default:                          legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the core memory stage (master) and the
// data-memory responder (slave).
//   req_valid_i/req_ready_o : request handshake
//   req_we_i, req_addr_i, req_wdata_i, req_wstrb_i : request payload
//   rsp_valid_o/rsp_ready_i : response handshake
//   rsp_rdata_o, rsp_err_o  : response payload
// Signal suffixes are from the responder's point of view.
interface data_mem_responder_if #(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned DWIDTH = 32
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [AWIDTH-1:0]     req_addr_i;
    logic [DWIDTH-1:0]     req_wdata_i;
    logic [DWIDTH/8-1:0]   req_wstrb_i;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DWIDTH-1:0]     rsp_rdata_o;
    logic                  rsp_err_o;

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wstrb_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wstrb_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

endinterface

// File: rtl/data_mem_responder_mem_word_array.sv
// Synchronous word array with per-byte-lane write enables and a registered read.
//   clk   : clock
//   we    : write enable (qualified by wstrb per lane)
//   wstrb : byte-lane write enables
//   index : word index for both read and write
//   wdata : lane-aligned write data
//   re    : read enable; rdata updates on the same edge
//   rdata : registered read word, held until the next read
// Contents and read register are not reset.
module data_mem_responder_mem_word_array #(
    parameter int unsigned DWIDTH      = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDXW        = 10
) (
    input  logic                clk,
    input  logic                we,
    input  logic [DWIDTH/8-1:0] wstrb,
    input  logic [IDXW-1:0]     index,
    input  logic [DWIDTH-1:0]   wdata,
    input  logic                re,
    output logic [DWIDTH-1:0]   rdata
);

    logic [DWIDTH-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < int'(DWIDTH / 8); i++) begin
                if (wstrb[i]) begin
                    mem_q[index][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem_q[index];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, commits byte-strobed
// stores to the word array on the accept edge, and presents the response
// LATENCY cycles after the accept cycle, held until rsp_ready_i.
//   clk  : clock
//   rst  : synchronous active-low reset
//   bus  : data_mem_responder_if.slave request/response bus
// Optional build macro DMEM_STRB_CHECK_EN: reject stores whose strobe is not an
// aligned byte, half-word, word or empty pattern (no write, rsp_err_o = 1).
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned       AWIDTH      = 32,
    parameter int unsigned       DWIDTH      = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR   = AWIDTH'(DefaultBaseAddr),
    parameter int unsigned       DEPTH_WORDS = 1024,
    parameter int unsigned       LATENCY     = 2
) (
    input logic                clk,
    input logic                rst,
    data_mem_responder_if.slave bus
);

    localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic              rsp_valid_q;
    logic              err_q;
    logic              load_ok_q;

    logic              accept;
    logic [AWIDTH-1:0] offset;
    logic              in_range;
    logic              strb_ok;
    logic              req_ok;
    logic [DWIDTH-1:0] rd_data;

    assign accept = bus.req_valid_i && (state_q == StIdle);

    // Offset is only meaningful when addr >= BASE_ADDR; the first term keeps a
    // wrapped subtraction from looking in range.
    assign offset   = bus.req_addr_i - BASE_ADDR;
    assign in_range = (bus.req_addr_i >= BASE_ADDR) &&
                      (64'(offset) < 64'(DEPTH_WORDS) * 64'd4);

`ifdef DMEM_STRB_CHECK_EN
    assign strb_ok = !bus.req_we_i || strb_legal(4'(bus.req_wstrb_i));
`else
    assign strb_ok = 1'b1;
`endif

    assign req_ok = in_range && strb_ok;

    data_mem_responder_mem_word_array #(
        .DWIDTH      (DWIDTH),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDXW        (IdxW)
    ) u_array (
        .clk   (clk),
        .we    (accept && bus.req_we_i && req_ok),
        .wstrb (bus.req_wstrb_i),
        .index (offset[IdxW+1:2]),
        .wdata (bus.req_wdata_i),
        .re    (accept && !bus.req_we_i && req_ok),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            load_ok_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        err_q     <= !req_ok;
                        load_ok_q <= req_ok && !bus.req_we_i;
                        if (LATENCY == 1) begin
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= 4'(LATENCY - 2);
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        state_q     <= StResp;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StResp: begin
                    if (bus.rsp_ready_i) begin
                        state_q     <= StIdle;
                        rsp_valid_q <= 1'b0;
                        err_q       <= 1'b0;
                        load_ok_q   <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req_ready_o = (state_q == StIdle);
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_err_o   = err_q;
    // Read register holds the last loaded word; only expose it for a good load.
    assign bus.rsp_rdata_o = (rsp_valid_q && load_ok_q) ? rd_data : '0;

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder end of the core's data-memory request interface: accepts one load/store request at a time from the datapath, commits byte-strobed writes to an internal word array, and returns read data after a fixed, parameterised latency through a valid/ready response handshake. It sits between the core's memory stage and the storage array and replaces the zero-latency combinational memory path, so the datapath can be exercised against a multi-cycle memory.

## Interface
- AWIDTH, 32, request address width
- DWIDTH, 32, data width; fixed multiple of 8
- BASE_ADDR, 32'h0100_0000, byte address of word 0
- DEPTH_WORDS, 1024, number of DWIDTH words in the array
- LATENCY, 2, cycles from request acceptance to rsp_valid_o; legal range 1..15
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- req_valid_i  in  1  request present
- req_ready_o  out  1  responder can accept a request
- req_we_i  in  1  1 = store, 0 = load
- req_addr_i  in  AWIDTH  byte address; bits [1:0] ignored for indexing
- req_wdata_i  in  DWIDTH  store data, already lane-aligned by the core
- req_wstrb_i  in  DWIDTH/8  byte-lane write enables
- rsp_valid_o  out  1  response available
- rsp_ready_i  in  1  core accepts response
- rsp_rdata_o  out  DWIDTH  full aligned word for loads; 0 for stores and errors
- rsp_err_o  out  1  request was rejected (range or strobe error)

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready_o = 1. On req_valid_i && req_ready_o (accept): latch rdata/err; LATENCY==1 → RESP, else → WAIT with cnt = LATENCY-2.
- WAIT: req_ready_o = 0; cnt decrements; cnt==0 → RESP.
- RESP: rsp_valid_o = 1, held with rdata/err stable until rsp_ready_i; on handshake → IDLE. No new request is accepted in RESP.
- Index = (req_addr_i - BASE_ADDR) >> 2. In range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS (unsigned compare, no wrap).
- Store: on the accept edge, each lane i with req_wstrb_i[i]=1 takes req_wdata_i[8i+7:8i]; other lanes unchanged. rsp_rdata_o = 0.
- Load: array word captured on the accept edge; strobe ignored.
- Out of range: no array write; rsp_rdata_o = 0, rsp_err_o = 1; timing identical to a good access.
- Store with all strobes 0: legal no-op, rsp_err_o = 0.
- Array contents are not reset.

## Timing
- Reset values: req_ready_o = 1, rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0, state IDLE, cnt 0.
- Accept at edge N → rsp_valid_o first high after edge N+LATENCY.
- Minimum request period = LATENCY+1 cycles when rsp_ready_i held high.
- Backpressure: rsp_ready_i low stalls indefinitely in RESP; outputs stable.
- Reset asserted mid-WAIT or mid-RESP: next edge → IDLE, pending response dropped; a store already accepted remains committed.
- One outstanding request; a load following a store to the same word returns the stored value.

## Configuration
- DMEM_STRB_CHECK_EN defined: a store whose strobe is not one of 0000, 0001<<k (k=0..3), 0011, 1100, 1111 is rejected: no write, rsp_err_o = 1.
- Undefined: any strobe pattern is written as given; rsp_err_o only reports range errors.

## Structure
- Shared package: FSM state enum (IDLE/WAIT/RESP), legal strobe constants, default BASE_ADDR.
- Sub-module: mem_word_array (synchronous word array, per-lane write enable, registered read); FSM, counter and range/strobe checks stay in the top.

## Test plan
- LATENCY=2, store 32'hDEADBEEF strb 1111 to 0x0100_0010, then load same address → rsp_rdata_o = 32'hDEADBEEF, rsp_valid_o exactly 2 cycles after each accept.
- Store 32'h0000_AB00 strb 0010 over 32'h1122_3344 → subsequent load returns 32'h1122_AB44.
- Load from 0x0100_0000 + 4*DEPTH_WORDS → rsp_err_o = 1, rsp_rdata_o = 0; array unchanged.
- Hold rsp_ready_i low 5 cycles in RESP → rsp_valid_o/rdata stable, req_ready_o = 0, second req_valid_i not accepted until handshake.
- Assert rst one cycle into WAIT → rsp_valid_o never rises, next cycle req_ready_o = 1, outputs at reset values.
- With DMEM_STRB_CHECK_EN, store strb 0101 → rsp_err_o = 1 and word unchanged; without the macro the two lanes are written and rsp_err_o = 0.
